hm2_bus_arb: RTL and testbench

Two-requester arbiter sharing the single hostmot2 register bus (16-bit address, 32-bit data) on the DE0-Nano DB25 build. Requester 0 is the HPS-to-FPGA bridge slave; requester 1 is the internal scan engine that polls the two 17-pin DB25 port registers. The block grants at most one transaction per clock with bounded-burst round-robin fairness. It drives the bus with registered strobes and routes each fixed-latency read return back to the requester that issued it.

---
 rtl/hm2_bus_pkg.sv | 18 +
 rtl/hm2_bus_arb_if.sv | 41 ++++
 rtl/hm2_rd_tag_pipe.sv | 35 +++
 rtl/hm2_bus_arb.sv | 161 ++++++++++++++++
 tb/tb_hm2_bus_arb.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hm2_bus_pkg.sv
// hm2_bus_pkg
// Shared types and default widths for the hostmot2 register bus arbiter.
//   req_id_t  : requester index (0 = HPS bridge, 1 = DB25 scan engine)
//   rd_tag_t  : read-return tag {valid, id} carried alongside the bus latency
//   DefAddrWidth / DefBusWidth : register bus widths used by the boardtype
package hm2_bus_pkg;

    localparam int DefAddrWidth = 16;
    localparam int DefBusWidth  = 32;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/hm2_bus_arb_if.sv
// hm2_bus_arb_if
// Bundles the two requester ports and the shared register bus.
//   req*/we*/addr*/wdata*  : requester transaction fields (held until granted)
//   gnt*                   : combinational accept
//   rvalid*/rdata*         : per-requester read return
//   bus_addr/bus_wdata/bus_write/bus_read : registered bus drive
//   bus_rdata              : fixed-latency read data from the register file
// Modports: slave = the arbiter, master = requesters plus bus device.
interface hm2_bus_arb_if
    import hm2_bus_pkg::*;
#(
    parameter int AddrWidth = DefAddrWidth,
    parameter int BusWidth  = DefBusWidth
) ();

    logic                 req0, req1;
    logic                 we0, we1;
    logic [AddrWidth-1:0] addr0, addr1;
    logic [BusWidth-1:0]  wdata0, wdata1;
    logic                 gnt0, gnt1;
    logic                 rvalid0, rvalid1;
    logic [BusWidth-1:0]  rdata0, rdata1;
    logic [AddrWidth-1:0] bus_addr;
    logic [BusWidth-1:0]  bus_wdata;
    logic                 bus_write;
    logic                 bus_read;
    logic [BusWidth-1:0]  bus_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               bus_addr, bus_wdata, bus_write, bus_read
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bus_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               bus_addr, bus_wdata, bus_write, bus_read
    );

endinterface

// File: rtl/hm2_rd_tag_pipe.sv
// hm2_rd_tag_pipe
// Delay line of read tags matching the register file's read latency.
//   clk, reset : clock and asynchronous active-high clear
//   tag_in     : tag pushed every cycle (valid only on a bus read)
//   tag_out    : tag emerging Depth cycles later, aligned with bus_rdata
module hm2_rd_tag_pipe
    import hm2_bus_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [Depth];

    // Clearing on reset drops every in-flight read so none can return later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < Depth; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[Depth-1];

endmodule

// File: rtl/hm2_bus_arb.sv
// hm2_bus_arb
// Two-requester round-robin arbiter for the hostmot2 register bus with a
// bounded burst per owner, registered bus strobes and routed read returns.
//   clk, reset : bus clock, asynchronous active-high reset
//   bus        : hm2_bus_arb_if.slave (requester ports + register bus)
// Parameters: AddrWidth, BusWidth, ReadLatency (1..4), MaxBurst (1..15).
module hm2_bus_arb
    import hm2_bus_pkg::*;
#(
    parameter int AddrWidth   = DefAddrWidth,
    parameter int BusWidth    = DefBusWidth,
    parameter int ReadLatency = 2,
    parameter int MaxBurst    = 4
) (
    input  logic         clk,
    input  logic         reset,
    hm2_bus_arb_if.slave bus
);

    localparam logic [3:0] BurstMax = 4'(MaxBurst);

    function automatic logic [3:0] burst_inc(input logic [3:0] cnt);
        return (cnt >= BurstMax) ? BurstMax : cnt + 4'd1;
    endfunction

    req_id_t              owner;
    logic [3:0]           burst_cnt;
    logic                 gnt_vld;
    req_id_t              gnt_id;
    logic                 sel_we;
    logic [AddrWidth-1:0] sel_addr;
    logic [BusWidth-1:0]  sel_wdata;

    logic [AddrWidth-1:0] bus_addr_p0;
    logic [BusWidth-1:0]  bus_wdata_p0;
    logic                 bus_write_p0;
    logic                 bus_read_p0;
    req_id_t              bus_id_p0;

    rd_tag_t              tag_in;
    rd_tag_t              tag_out;

    logic                 rvalid0_p1, rvalid1_p1;
    logic [BusWidth-1:0]  rdata0_p1, rdata1_p1;

    // Grant decision: depends on requests and arbitration state only, so
    // there is no path from bus_rdata. Held low while reset is asserted.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = owner;
        if (!reset) begin
            unique case ({bus.req1, bus.req0})
                2'b01: begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b0;
                end
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt_id  = 1'b1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt_id  = (burst_cnt < BurstMax) ? owner : ~owner;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0 = gnt_vld && (gnt_id == 1'b0);
    assign bus.gnt1 = gnt_vld && (gnt_id == 1'b1);

    always_comb begin
        sel_we    = bus.we0;
        sel_addr  = bus.addr0;
        sel_wdata = bus.wdata0;
        if (gnt_id == 1'b1) begin
            sel_we    = bus.we1;
            sel_addr  = bus.addr1;
            sel_wdata = bus.wdata1;
        end
    end

    // An idle cycle clears the burst so a fresh contention starts with the
    // current owner getting a full burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= 1'b0;
            burst_cnt <= 4'd0;
        end else if (gnt_vld) begin
            if (gnt_id == owner) begin
                burst_cnt <= burst_inc(burst_cnt);
            end else begin
                owner     <= gnt_id;
                burst_cnt <= 4'd1;
            end
        end else begin
            burst_cnt <= 4'd0;
        end
    end

    // ---- stage p0: granted request registered onto the bus ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_addr_p0  <= '0;
            bus_wdata_p0 <= '0;
            bus_write_p0 <= 1'b0;
            bus_read_p0  <= 1'b0;
            bus_id_p0    <= 1'b0;
        end else begin
            bus_write_p0 <= gnt_vld && sel_we;
            bus_read_p0  <= gnt_vld && !sel_we;
            if (gnt_vld) begin
                bus_addr_p0  <= sel_addr;
                bus_wdata_p0 <= sel_wdata;
                bus_id_p0    <= gnt_id;
            end
        end
    end

    assign bus.bus_addr  = bus_addr_p0;
    assign bus.bus_wdata = bus_wdata_p0;
    assign bus.bus_write = bus_write_p0;
    assign bus.bus_read  = bus_read_p0;

    assign tag_in = {bus_read_p0, bus_id_p0};

    hm2_rd_tag_pipe #(
        .Depth (ReadLatency)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // ---- stage p1: tag tail aligned with bus_rdata, routed to issuer ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0_p1 <= 1'b0;
            rvalid1_p1 <= 1'b0;
            rdata0_p1  <= '0;
            rdata1_p1  <= '0;
        end else begin
            rvalid0_p1 <= tag_out.valid && (tag_out.id == 1'b0);
            rvalid1_p1 <= tag_out.valid && (tag_out.id == 1'b1);
            if (tag_out.valid && (tag_out.id == 1'b0)) begin
                rdata0_p1 <= bus.bus_rdata;
            end
            if (tag_out.valid && (tag_out.id == 1'b1)) begin
                rdata1_p1 <= bus.bus_rdata;
            end
        end
    end

    assign bus.rvalid0 = rvalid0_p1;
    assign bus.rvalid1 = rvalid1_p1;
    assign bus.rdata0  = rdata0_p1;
    assign bus.rdata1  = rdata1_p1;

endmodule

// File: tb/tb_hm2_bus_arb.sv
// tb_hm2_bus_arb
// Directed bench for hm2_bus_arb: a transaction-level model (grant rule,
// scheduled bus strobes and read returns keyed by cycle) checked every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_hm2_bus_arb;
    import hm2_bus_pkg::*;

    localparam int RL = 2;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hm2_bus_arb_if #(.AddrWidth(16), .BusWidth(32)) bif ();

    hm2_bus_arb #(
        .AddrWidth   (16),
        .BusWidth    (32),
        .ReadLatency (RL),
        .MaxBurst    (MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [15:0] a);
        case (a)
            16'h0100: return 32'hDEADBEEF;
            16'h0200: return 32'h11111111;
            16'h0204: return 32'h22222222;
            default:  return {16'hC0DE, a};
        endcase
    endfunction

    // Transaction schedule indexed by cycle modulo 16.
    bit          e_bv [16];
    bit          e_bwe[16];
    logic [15:0] e_ba [16];
    logic [31:0] e_bd [16];
    bit          e_rv [2][16];
    logic [31:0] e_rd [2][16];
    bit          dev_v[16];
    logic [31:0] dev_d[16];

    int          m_owner = 0;
    int          m_cnt   = 0;
    logic [15:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata [2];

    int rv0_seen = 0;
    int rv1_seen = 0;
    int gnt1_seen = 0;

    always @(negedge clk) begin : compare
        int s, s1, sr, g;
        logic        t_we;
        logic [15:0] t_a;
        logic [31:0] t_d;
        s = cyc % 16;

        // register-file model: returns data RL cycles after bus_read
        bif.bus_rdata = dev_v[s] ? dev_d[s] : (32'h0BAD0000 | 32'(cyc));
        dev_v[s] = 1'b0;
        if (!reset && bif.bus_read) begin
            dev_v[(cyc + RL) % 16] = 1'b1;
            dev_d[(cyc + RL) % 16] = mem_val(bif.bus_addr);
        end

        if (bif.rvalid0) rv0_seen++;
        if (bif.rvalid1) rv1_seen++;
        if (bif.gnt1)    gnt1_seen++;

        if (reset) begin
            chk("rst_gnt0",    32'(bif.gnt0), 0);
            chk("rst_gnt1",    32'(bif.gnt1), 0);
            chk("rst_rvalid0", 32'(bif.rvalid0), 0);
            chk("rst_rvalid1", 32'(bif.rvalid1), 0);
            chk("rst_rdata0",  bif.rdata0, 0);
            chk("rst_rdata1",  bif.rdata1, 0);
            chk("rst_addr",    32'(bif.bus_addr), 0);
            chk("rst_wdata",   bif.bus_wdata, 0);
            chk("rst_write",   32'(bif.bus_write), 0);
            chk("rst_read",    32'(bif.bus_read), 0);
            for (int i = 0; i < 16; i++) begin
                e_bv[i] = 1'b0; e_rv[0][i] = 1'b0; e_rv[1][i] = 1'b0; dev_v[i] = 1'b0;
            end
            m_owner = 0; m_cnt = 0; m_addr = '0; m_wdata = '0;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else begin
            g = -1;
            if (bif.req0 && !bif.req1)      g = 0;
            else if (bif.req1 && !bif.req0) g = 1;
            else if (bif.req0 && bif.req1)  g = (m_cnt < MB) ? m_owner : 1 - m_owner;

            chk("gnt0", 32'(bif.gnt0), 32'(g == 0));
            chk("gnt1", 32'(bif.gnt1), 32'(g == 1));

            if (e_bv[s]) begin
                m_addr  = e_ba[s];
                m_wdata = e_bd[s];
            end
            chk("bus_read",  32'(bif.bus_read),  32'(e_bv[s] && !e_bwe[s]));
            chk("bus_write", 32'(bif.bus_write), 32'(e_bv[s] && e_bwe[s]));
            chk("bus_addr",  32'(bif.bus_addr),  32'(m_addr));
            chk("bus_wdata", bif.bus_wdata, m_wdata);
            e_bv[s] = 1'b0;

            if (e_rv[0][s]) m_rdata[0] = e_rd[0][s];
            if (e_rv[1][s]) m_rdata[1] = e_rd[1][s];
            chk("rvalid0", 32'(bif.rvalid0), 32'(e_rv[0][s]));
            chk("rvalid1", 32'(bif.rvalid1), 32'(e_rv[1][s]));
            chk("rdata0",  bif.rdata0, m_rdata[0]);
            chk("rdata1",  bif.rdata1, m_rdata[1]);
            e_rv[0][s] = 1'b0;
            e_rv[1][s] = 1'b0;

            if (g >= 0) begin
                t_we = (g == 0) ? bif.we0   : bif.we1;
                t_a  = (g == 0) ? bif.addr0 : bif.addr1;
                t_d  = (g == 0) ? bif.wdata0 : bif.wdata1;
                s1 = (cyc + 1) % 16;
                e_bv[s1] = 1'b1; e_bwe[s1] = t_we; e_ba[s1] = t_a; e_bd[s1] = t_d;
                if (!t_we) begin
                    sr = (cyc + 2 + RL) % 16;
                    e_rv[g][sr] = 1'b1;
                    e_rd[g][sr] = mem_val(t_a);
                end
                if (g == m_owner) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                else begin
                    m_owner = g;
                    m_cnt   = 1;
                end
            end else begin
                m_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    task automatic set0(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
        bif.req0 = r; bif.we0 = w; bif.addr0 = a; bif.wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
        bif.req1 = r; bif.we1 = w; bif.addr1 = a; bif.wdata1 = d;
    endtask

    task automatic idle();
        bif.req0 = 1'b0;
        bif.req1 = 1'b0;
    endtask

    task automatic one(input int p, input logic w, input logic [15:0] a, input logic [31:0] d);
        idle();
        if (p == 0) set0(1'b1, w, a, d);
        else        set1(1'b1, w, a, d);
        tick();
    endtask

    int seq_exp [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int got, n, b0, b1, bg;

    initial begin
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        bif.bus_rdata = '0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;

        // reset state
        repeat (3) tick();
        samp();
        chk("lit_rst_read", 32'(bif.bus_read), 0);
        chk("lit_rst_rdata0", bif.rdata0, 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // single read from port 0
        set0(1'b1, 1'b0, 16'h0100, 32'h0);
        samp();
        chk("lit_t1_gnt0", 32'(bif.gnt0), 1);
        tick();
        idle();
        samp();
        chk("lit_t1_bus_read", 32'(bif.bus_read), 1);
        chk("lit_t1_bus_addr", 32'(bif.bus_addr), 32'h0100);
        repeat (3) tick();
        samp();
        chk("lit_t1_rvalid0", 32'(bif.rvalid0), 1);
        chk("lit_t1_rdata0", bif.rdata0, 32'hDEADBEEF);
        chk("lit_t1_rvalid1", 32'(bif.rvalid1), 0);
        repeat (2) tick();

        // continuous contention
        set0(1'b1, 1'b0, 16'h0100, 32'h0);
        set1(1'b1, 1'b0, 16'h0204, 32'h0);
        for (int i = 0; i < 12; i++) begin
            samp();
            got = bif.gnt0 ? 0 : (bif.gnt1 ? 1 : 2);
            chk($sformatf("lit_t2_seq%0d", i), 32'(got), 32'(seq_exp[i]));
            tick();
        end
        idle();
        repeat (6) tick();

        // lone requester 1, then requester 0 joins
        set1(1'b1, 1'b0, 16'h0204, 32'h0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            samp();
            if (bif.gnt1) n++;
            tick();
        end
        chk("lit_t3_gnt1_count", 32'(n), 10);
        set0(1'b1, 1'b0, 16'h0200, 32'h0);
        samp();
        chk("lit_t3_gnt0_next", 32'(bif.gnt0), 1);
        chk("lit_t3_gnt1_off", 32'(bif.gnt1), 0);
        tick();
        idle();
        repeat (6) tick();

        // interleaved ownership with reads and writes
        b0 = rv0_seen;
        b1 = rv1_seen;
        one(0, 1'b0, 16'h0200, 32'h0);
        one(1, 1'b0, 16'h0204, 32'h0);
        one(0, 1'b1, 16'h0200, 32'hAAAA5555);
        one(1, 1'b0, 16'h0204, 32'h0);
        one(0, 1'b0, 16'h0200, 32'h0);
        one(1, 1'b1, 16'h0204, 32'h5555AAAA);
        idle();
        repeat (8) tick();
        chk("lit_t4_rv0_count", 32'(rv0_seen - b0), 2);
        chk("lit_t4_rv1_count", 32'(rv1_seen - b1), 2);
        chk("lit_t4_rdata0", bif.rdata0, 32'h11111111);
        chk("lit_t4_rdata1", bif.rdata1, 32'h22222222);

        // reset one cycle after bus_read
        set0(1'b1, 1'b0, 16'h0100, 32'h0);
        tick();
        idle();
        tick();
        reset = 1'b1;
        set0(1'b1, 1'b1, 16'h0300, 32'h12345678);
        set1(1'b1, 1'b1, 16'h0304, 32'h87654321);
        b0 = rv0_seen;
        b1 = rv1_seen;
        samp();
        chk("lit_t5_rst_rdata0", bif.rdata0, 0);
        chk("lit_t5_rst_addr", 32'(bif.bus_addr), 0);
        chk("lit_t5_rst_gnt0", 32'(bif.gnt0), 0);
        repeat (2) tick();
        reset = 1'b0;
        samp();
        chk("lit_t5_first_gnt0", 32'(bif.gnt0), 1);
        chk("lit_t5_first_gnt1", 32'(bif.gnt1), 0);
        tick();
        idle();
        repeat (8) tick();
        chk("lit_t5_no_rv0", 32'(rv0_seen - b0), 0);
        chk("lit_t5_no_rv1", 32'(rv1_seen - b1), 0);

        // withdrawn request from port 1 during a port-0 burst
        b1 = rv1_seen;
        bg = gnt1_seen;
        set0(1'b1, 1'b0, 16'h0200, 32'h0);
        tick();
        set1(1'b1, 1'b0, 16'h0204, 32'h0);
        repeat (2) tick();
        bif.req1 = 1'b0;
        repeat (3) tick();
        idle();
        repeat (8) tick();
        chk("lit_t6_no_gnt1", 32'(gnt1_seen - bg), 0);
        chk("lit_t6_no_rv1", 32'(rv1_seen - b1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
